arb_mux: RTL and testbench

Parametrised N-channel registered multiplexer with valid/ready handshakes, successor to the combinational 2:1 scale mux in the 8-bit CPU datapath. It routes one of `CHANNELS` input streams of `WIDTH` bits into a single registered output stage. The channel is either chosen by an explicit select, as in the original mux, or by a round-robin arbiter. It sits between multiple bus masters (fetch, ALU writeback, I/O) and a shared single-port consumer.

---
 rtl/arb_mux_pkg.sv | 26 ++
 rtl/arb_mux_if.sv | 54 +++++
 rtl/rr_pick.sv | 32 +++
 rtl/arb_mux.sv | 143 ++++++++++++++
 tb/tb_arb_mux.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and helpers for the arb_mux channel multiplexer.
//   MODE_SEL / MODE_ARB  values of the mode input (explicit select vs. arbitration)
//   DEF_WIDTH / DEF_CHANNELS  default data width and channel count
//   clog2()  constant-foldable ceil(log2(n)) used to size channel indices
package arb_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ARB = 1'b1;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_if.sv
// arb_mux_if: bundle of the arb_mux stream signals.
//   in_data   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel beat valid
//   in_ready  CHANNELS        per-channel accept (at most one high)
//   mode      1               0 = select, 1 = arbitrate
//   sel       SEL_W           channel index for select mode
//   out_data  WIDTH           registered output beat
//   out_chan  SEL_W           source channel of the held beat
//   out_valid 1               output register holds a beat
//   out_ready 1               consumer accepts the beat
// Modports: slave = the multiplexer, master = the sources/consumer side.
interface arb_mux_if #(
  parameter int unsigned WIDTH    = arb_mux_pkg::DEF_WIDTH,
  parameter int unsigned CHANNELS = arb_mux_pkg::DEF_CHANNELS
) ();
  import arb_mux_pkg::*;

  localparam int unsigned SEL_W = clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_chan,
    output out_valid
  );

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_chan,
    input  out_valid
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req_i    N      request vector
//   ptr_i    IDX_W  index with highest priority this cycle
//   grant_o  IDX_W  first requesting index at or above ptr_i, wrapping modulo N
//   hit_o    1      at least one request is set
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             hit_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx     = 0;
    found   = 1'b0;
    grant_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        grant_o = IDX_W'(idx);
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel registered multiplexer with valid/ready handshakes.
// Routes one of CHANNELS input streams into a one-entry output register, chosen either by
// an explicit select (mode = 0) or by an arbiter (mode = 1).
//   clk   single clock, rising edge
//   rst_  synchronous active-low reset
//   bus   arb_mux_if.slave: in_data/in_valid/in_ready, mode, sel,
//         out_data/out_chan/out_valid/out_ready
// Build option: ARB_MUX_RR_EN
//   defined   - arbitrate mode is round-robin, starting the search at a pointer that
//               advances past each channel granted in arbitrate mode
//   undefined - arbitrate mode is fixed priority (lowest index wins), no pointer state
module arb_mux #(
  parameter int unsigned WIDTH    = arb_mux_pkg::DEF_WIDTH,
  parameter int unsigned CHANNELS = arb_mux_pkg::DEF_CHANNELS
) (
  input  logic     clk,
  input  logic     rst_,
  arb_mux_if.slave bus
);
  import arb_mux_pkg::*;

  localparam int unsigned SEL_W = clog2(CHANNELS);

  logic                load;
  logic                xfer;
  logic                grant_hit;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W-1:0]    arb_grant;
  logic                arb_hit;
  logic [CHANNELS-1:0] in_ready;
  logic [WIDTH-1:0]    grant_data;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;

  // The register can take a new beat when empty or when its beat leaves this cycle.
  assign load = !out_valid_q || bus.out_ready;

`ifdef ARB_MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  rr_pick #(
    .N     (CHANNELS),
    .IDX_W (SEL_W)
  ) u_rr_pick (
    .req_i   (bus.in_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .hit_o   (arb_hit)
  );

  // Only arbitrated transfers rotate priority; select-mode traffic leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (bus.mode == MODE_ARB)) begin
      ptr_d = (32'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: scan downward so the lowest requesting index is the last write.
  always_comb begin
    arb_grant = '0;
    arb_hit   = 1'b0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        arb_grant = SEL_W'(i);
        arb_hit   = 1'b1;
      end
    end
  end
`endif

  // Select mode grants sel whether or not that channel is valid; an index past the last
  // channel (non-power-of-2 CHANNELS) grants nothing.
  always_comb begin
    if (bus.mode == MODE_SEL) begin
      grant     = bus.sel;
      grant_hit = (32'(bus.sel) < CHANNELS);
    end else begin
      grant     = arb_grant;
      grant_hit = arb_hit;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_ && load && grant_hit && (32'(grant) == i);
    end
  end

  assign xfer = |(bus.in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (32'(grant) == i) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A load without a transfer empties the register but keeps the last data/channel.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_chan_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
  import arb_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected beats for the 4-channel instance: {chan[1:0], data[7:0]}.
  logic [9:0] sb[$];
  logic [9:0] exp_beat;

  arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
  arb_mux_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  arb_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus4)
  );

  arb_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus3)
  );

  // Inputs change on the falling edge; checks run 1 time unit later.
  always @(negedge clk) begin
    #1;
    if (rst_ && bus4.out_valid && bus4.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got chan=%0d data=%h required no beat",
                 bus4.out_chan, bus4.out_data);
      end else begin
        exp_beat = sb.pop_front();
        if ({bus4.out_chan, bus4.out_data} !== exp_beat) begin
          errors++;
          $display("FAIL sb_beat got chan=%0d data=%h required chan=%0d data=%h",
                   bus4.out_chan, bus4.out_data, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk);
    rst_           = 1'b0;
    bus4.mode      = MODE_SEL;
    bus4.sel       = 2'd0;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    bus3.mode      = MODE_SEL;
    bus3.sel       = 2'd0;
    bus3.in_valid  = 3'b111;
    bus3.out_ready = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready4 got %b required 0000", bus4.in_ready);
    end
    checks++;
    if (bus3.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_in_ready3 got %b required 000", bus3.in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b required 0", bus4.out_valid);
    end
    checks++;
    if (bus4.out_data !== 8'h00 || bus4.out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_out_regs got data=%h chan=%0d required data=00 chan=0",
               bus4.out_data, bus4.out_chan);
    end
    checks++;
    if (bus3.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid3 got %b required 0", bus3.out_valid);
    end
    @(negedge clk);
    rst_          = 1'b1;
    bus4.in_valid = 4'b0000;
    bus3.in_valid = 3'b000;
  endtask

  task automatic test_select();
    @(negedge clk);
    bus4.mode           = MODE_SEL;
    bus4.sel            = 2'd2;
    bus4.in_data[23:16] = 8'hA5;
    bus4.in_valid       = 4'b0100;
    bus4.out_ready      = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL sel_in_ready got %b required 0100", bus4.in_ready);
    end
    sb.push_back({2'd2, 8'hA5});
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'hA5 || bus4.out_chan !== 2'd2) begin
      errors++;
      $display("FAIL sel_out got valid=%b data=%h chan=%0d required valid=1 data=a5 chan=2",
               bus4.out_valid, bus4.out_data, bus4.out_chan);
    end
    checks++;
    if (bus4.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL sel_ready_no_valid got %b required 0100", bus4.in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'hA5 || bus4.out_chan !== 2'd2) begin
      errors++;
      $display("FAIL sel_empty_hold got valid=%b data=%h chan=%0d required valid=0 data=a5 chan=2",
               bus4.out_valid, bus4.out_data, bus4.out_chan);
    end
  endtask

`ifdef ARB_MUX_RR_EN
  task automatic test_round_robin();
    logic [3:0] exp_ir;
    int         g;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus4.mode      = MODE_ARB;
      bus4.in_data   = 32'h13121110;
      bus4.in_valid  = 4'b1111;
      bus4.out_ready = 1'b1;
      #1;
      g      = k % 4;
      exp_ir = 4'b0001 << g;
      checks++;
      if (bus4.in_ready !== exp_ir) begin
        errors++;
        $display("FAIL rr_in_ready step=%0d got %b required %b", k, bus4.in_ready, exp_ir);
      end
      sb.push_back({2'(g), 8'(8'h10 + g)});
    end
    @(negedge clk);
    bus4.in_valid = 4'b0000;
  endtask
`else
  task automatic test_fixed_priority();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus4.mode           = MODE_ARB;
      bus4.in_data[15:8]  = 8'(8'h40 + k);
      bus4.in_data[31:24] = 8'hEE;
      bus4.in_valid       = 4'b1010;
      bus4.out_ready      = 1'b1;
      #1;
      checks++;
      if (bus4.in_ready !== 4'b0010) begin
        errors++;
        $display("FAIL fixed_in_ready step=%0d got %b required 0010", k, bus4.in_ready);
      end
      sb.push_back({2'd1, 8'(8'h40 + k)});
    end
    @(negedge clk);
    bus4.in_valid = 4'b0000;
  endtask
`endif

  task automatic test_backpressure();
    logic [3:0] exp_ir;
    @(negedge clk);
    bus4.mode          = MODE_ARB;
    bus4.in_data[7:0]  = 8'h77;
    bus4.in_valid      = 4'b0001;
    bus4.out_ready     = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first_ready got %b required 0001", bus4.in_ready);
    end
    sb.push_back({2'd0, 8'h77});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus4.in_data[23:16] = 8'h88;
      bus4.in_valid       = 4'b0100;
      bus4.out_ready      = 1'b0;
      #1;
      checks++;
      if (bus4.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_in_ready cycle=%0d got %b required 0000", k, bus4.in_ready);
      end
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h77 || bus4.out_chan !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%h chan=%0d required 1 77 0",
                 k, bus4.out_valid, bus4.out_data, bus4.out_chan);
      end
    end
    @(negedge clk);
    bus4.out_ready = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready got %b required 0100", bus4.in_ready);
    end
    sb.push_back({2'd2, 8'h88});
    @(negedge clk);
    bus4.in_data[7:0]   = 8'h31;
    bus4.in_data[31:24] = 8'h33;
    bus4.in_valid       = 4'b1001;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'd2 || bus4.out_data !== 8'h88) begin
      errors++;
      $display("FAIL bp_no_bubble got valid=%b data=%h chan=%0d required 1 88 2",
               bus4.out_valid, bus4.out_data, bus4.out_chan);
    end
`ifdef ARB_MUX_RR_EN
    exp_ir = 4'b1000;
`else
    exp_ir = 4'b0001;
`endif
    checks++;
    if (bus4.in_ready !== exp_ir) begin
      errors++;
      $display("FAIL bp_ptr_grant got %b required %b", bus4.in_ready, exp_ir);
    end
    if (exp_ir[3]) sb.push_back({2'd3, 8'h33});
    else sb.push_back({2'd0, 8'h31});
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    logic [3:0] exp_ir;
    @(negedge clk);
    bus4.mode          = MODE_ARB;
    bus4.in_data[15:8] = 8'h99;
    bus4.in_valid      = 4'b0010;
    bus4.out_ready     = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_mid_accept got %b required 0010", bus4.in_ready);
    end
    sb.push_back({2'd1, 8'h99});
    @(negedge clk);
    bus4.in_valid  = 4'b0000;
    bus4.out_ready = 1'b0;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'd1) begin
      errors++;
      $display("FAIL rst_mid_held got valid=%b chan=%0d required 1 1",
               bus4.out_valid, bus4.out_chan);
    end
    @(negedge clk);
    rst_           = 1'b0;
    bus4.in_data   = 32'h13121110;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_in_ready got %b required 0000", bus4.in_ready);
    end
    @(negedge clk);
    rst_ = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h00 || bus4.out_chan !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_regs got valid=%b data=%h chan=%0d required 0 00 0",
               bus4.out_valid, bus4.out_data, bus4.out_chan);
    end
    checks++;
    if (bus4.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_first_grant got %b required 0001", bus4.in_ready);
    end
    sb.push_back({2'd0, 8'h10});
    @(negedge clk);
    #1;
`ifdef ARB_MUX_RR_EN
    exp_ir = 4'b0010;
`else
    exp_ir = 4'b0001;
`endif
    checks++;
    if (bus4.in_ready !== exp_ir) begin
      errors++;
      $display("FAIL rst_mid_second_grant got %b required %b", bus4.in_ready, exp_ir);
    end
    if (exp_ir[1]) sb.push_back({2'd1, 8'h11});
    else sb.push_back({2'd0, 8'h10});
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_invalid_select();
    @(negedge clk);
    bus3.mode          = MODE_SEL;
    bus3.sel           = 2'd1;
    bus3.in_data[15:8] = 8'h5A;
    bus3.in_valid      = 3'b010;
    bus3.out_ready     = 1'b0;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b010) begin
      errors++;
      $display("FAIL inv_sel_setup got %b required 010", bus3.in_ready);
    end
    @(negedge clk);
    bus3.sel      = 2'd3;
    bus3.in_valid = 3'b111;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL inv_sel_ready_held got %b required 000", bus3.in_ready);
    end
    checks++;
    if (bus3.out_valid !== 1'b1 || bus3.out_data !== 8'h5A || bus3.out_chan !== 2'd1) begin
      errors++;
      $display("FAIL inv_sel_beat got valid=%b data=%h chan=%0d required 1 5a 1",
               bus3.out_valid, bus3.out_data, bus3.out_chan);
    end
    @(negedge clk);
    bus3.out_ready = 1'b1;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL inv_sel_ready_pop got %b required 000", bus3.in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL inv_sel_drained got valid=%b ready=%b required 0 000",
               bus3.out_valid, bus3.in_ready);
    end
    bus3.in_valid = 3'b000;
  endtask

  initial begin
    bus4.in_data   = '0;
    bus4.in_valid  = '0;
    bus4.mode      = MODE_SEL;
    bus4.sel       = '0;
    bus4.out_ready = 1'b0;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.mode      = MODE_SEL;
    bus3.sel       = '0;
    bus3.out_ready = 1'b0;

    test_reset();
    test_select();
`ifdef ARB_MUX_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_backpressure();
    test_reset_mid_stream();
    test_invalid_select();

    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d beats required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
